// File: rtl/board_pkg.sv
// Shared definitions for the board_ctrl cell store: grid geometry,
// cell-status codes, requester result codes, FSM states and address helpers.
package board_pkg;

    localparam int GRID_W     = 10;
    localparam int GRID_H     = 10;
    localparam int CELL_COUNT = GRID_W * GRID_H;
    localparam int ADDR_W     = 7;

    typedef enum logic [1:0] {
        CELL_FREE     = 2'b00,
        CELL_OCC      = 2'b01,
        CELL_HIT      = 2'b10,
        CELL_OUTBOUND = 2'b11
    } cell_t;

    // Result codes; place and fire share the 2-bit result bus.
    localparam logic [1:0] RES_PLACE_OK     = 2'b00;
    localparam logic [1:0] RES_PLACE_OCC    = 2'b01;
    localparam logic [1:0] RES_FIRE_MISS    = 2'b00;
    localparam logic [1:0] RES_FIRE_HIT     = 2'b01;
    localparam logic [1:0] RES_FIRE_REPEAT  = 2'b10;
    localparam logic [1:0] RES_OUT_OF_RANGE = 2'b11;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'b00,
        ST_IDLE  = 2'b01,
        ST_EXEC  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    function automatic logic cell_in_range(input logic [3:0] x, input logic [3:0] y);
        return (x < 4'(GRID_W)) && (y < 4'(GRID_H));
    endfunction

    // y*10 + x without a multiplier.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [3:0] x, input logic [3:0] y);
        logic [ADDR_W-1:0] w_y;
        w_y = {3'b000, y};
        return (w_y << 3) + (w_y << 1) + {3'b000, x};
    endfunction

endpackage

// File: rtl/board_rr_arb.sv
// Two-input round-robin arbiter. Bit 0 is the placement port, bit 1 the
// fire port. On a tie the port not granted last wins; the history only
// moves when the grant is actually consumed (i_advance).
module board_rr_arb (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    logic r_last_fire;

    // Combinational one-hot grant from pending requests and history.
    always_comb begin
        o_grant = 2'b00;
        if (i_req == 2'b11) begin
            o_grant = r_last_fire ? 2'b01 : 2'b10;
        end else begin
            o_grant = i_req;
        end
    end

    // Remember which port was served; resets to placement so fire wins the first tie.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_last_fire <= 1'b0;
        end else if (i_advance) begin
            if (o_grant[1]) begin
                r_last_fire <= 1'b1;
            end else if (o_grant[0]) begin
                r_last_fire <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/board_ctrl.sv
// board_ctrl: 10x10 cell-status store with a never-stalled display read port
// and an arbitrated read-modify-write path for placement and fire requests.
// Optional macro BOARD_HIT_COUNTER_EN adds placed/hit counters driving all_sunk;
// without it all_sunk is tied low.
//
// state    | meaning
// ST_CLEAR | sweep writes free to every cell, busy high, requests ignored
// ST_IDLE  | waiting; clear_req first, otherwise grant one pending request
// ST_EXEC  | read target cell, write updated status, latch result
// ST_DONE  | ack pulse to the granted port, then back to idle
module board_ctrl
    import board_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [3:0] rd_cell_x,
    input  logic [3:0] rd_cell_y,
    output logic [1:0] rd_status,
    input  logic       place_req,
    input  logic [3:0] place_x,
    input  logic [3:0] place_y,
    output logic       place_ack,
    input  logic       fire_req,
    input  logic [3:0] fire_x,
    input  logic [3:0] fire_y,
    output logic       fire_ack,
    output logic [1:0] result,
    input  logic       clear_req,
    output logic       busy,
    output logic       all_sunk
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_sweep_cnt;
    logic [3:0]        r_tgt_x;
    logic [3:0]        r_tgt_y;
    logic              r_tgt_fire;
    logic              r_place_ack;
    logic              r_fire_ack;
    logic [1:0]        r_result;
    logic              r_busy;
    logic [1:0]        r_rd_status;
    cell_t             r_mem [CELL_COUNT];

    logic [1:0]        w_req;
    logic [1:0]        w_grant;
    logic              w_advance;
    logic              w_tgt_in;
    logic [ADDR_W-1:0] w_tgt_addr;
    cell_t             w_tgt_cell;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    cell_t             w_wdata;
    logic [1:0]        w_res;
    logic              w_rd_in;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_req     = {fire_req, place_req};
    assign w_advance = (r_state == ST_IDLE) && !clear_req && (|w_req);

    board_rr_arb u_arb (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .i_req     (w_req),
        .i_advance (w_advance),
        .o_grant   (w_grant)
    );

    assign w_tgt_in   = cell_in_range(r_tgt_x, r_tgt_y);
    assign w_tgt_addr = cell_addr(r_tgt_x, r_tgt_y);
    assign w_tgt_cell = w_tgt_in ? r_mem[w_tgt_addr] : CELL_OUTBOUND;

    // Write-port decode: sweep writes in CLEAR, read-modify-write outcome in EXEC.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_sweep_cnt;
        w_wdata = CELL_FREE;
        w_res   = RES_OUT_OF_RANGE;
        case (r_state)
            ST_CLEAR: begin
                w_we = 1'b1;
            end
            ST_EXEC: begin
                w_waddr = w_tgt_addr;
                if (!w_tgt_in) begin
                    w_res = RES_OUT_OF_RANGE;
                end else if (r_tgt_fire) begin
                    case (w_tgt_cell)
                        CELL_OCC: begin
                            w_we    = 1'b1;
                            w_wdata = CELL_HIT;
                            w_res   = RES_FIRE_HIT;
                        end
                        CELL_FREE: w_res = RES_FIRE_MISS;
                        CELL_HIT:  w_res = RES_FIRE_REPEAT;
                        default:   w_res = RES_OUT_OF_RANGE;
                    endcase
                end else begin
                    if (w_tgt_cell == CELL_FREE) begin
                        w_we    = 1'b1;
                        w_wdata = CELL_OCC;
                        w_res   = RES_PLACE_OK;
                    end else begin
                        w_res = RES_PLACE_OCC;
                    end
                end
            end
            default: ;
        endcase
    end

    // Single write port into the store; contents are initialised by the sweep, not reset.
    always_ff @(posedge clk_in) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Sequencing FSM with registered ack/result/busy.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= ST_CLEAR;
            r_sweep_cnt <= '0;
            r_tgt_x     <= '0;
            r_tgt_y     <= '0;
            r_tgt_fire  <= 1'b0;
            r_place_ack <= 1'b0;
            r_fire_ack  <= 1'b0;
            r_result    <= 2'b00;
            r_busy      <= 1'b1;
        end else begin
            r_place_ack <= 1'b0;
            r_fire_ack  <= 1'b0;
            case (r_state)
                ST_CLEAR: begin
                    if (r_sweep_cnt == ADDR_W'(CELL_COUNT - 1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_sweep_cnt <= r_sweep_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (clear_req) begin
                        r_state     <= ST_CLEAR;
                        r_sweep_cnt <= '0;
                        r_busy      <= 1'b1;
                    end else if (w_grant[1]) begin
                        r_tgt_x    <= fire_x;
                        r_tgt_y    <= fire_y;
                        r_tgt_fire <= 1'b1;
                        r_state    <= ST_EXEC;
                    end else if (w_grant[0]) begin
                        r_tgt_x    <= place_x;
                        r_tgt_y    <= place_y;
                        r_tgt_fire <= 1'b0;
                        r_state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_result    <= w_res;
                    r_place_ack <= !r_tgt_fire;
                    r_fire_ack  <= r_tgt_fire;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

    assign w_rd_in   = cell_in_range(rd_cell_x, rd_cell_y);
    assign w_rd_addr = cell_addr(rd_cell_x, rd_cell_y);

    // Display read port: one-cycle latency, old data wins on a same-edge write.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rd_status <= CELL_FREE;
        end else if (r_busy) begin
            r_rd_status <= CELL_FREE;
        end else if (!w_rd_in) begin
            r_rd_status <= CELL_OUTBOUND;
        end else begin
            r_rd_status <= r_mem[w_rd_addr];
        end
    end

    assign rd_status = r_rd_status;
    assign place_ack = r_place_ack;
    assign fire_ack  = r_fire_ack;
    assign result    = r_result;
    assign busy      = r_busy;

`ifdef BOARD_HIT_COUNTER_EN
    logic [6:0] r_occ_count;
    logic [6:0] r_hit_count;
    logic       r_all_sunk;

    // Placed/hit tallies; both restart with every sweep.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_occ_count <= '0;
            r_hit_count <= '0;
            r_all_sunk  <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && clear_req) begin
                r_occ_count <= '0;
                r_hit_count <= '0;
            end else if ((r_state == ST_EXEC) && w_we) begin
                if (r_tgt_fire) begin
                    r_hit_count <= r_hit_count + 1'b1;
                end else begin
                    r_occ_count <= r_occ_count + 1'b1;
                end
            end
            r_all_sunk <= (r_occ_count != '0) && (r_hit_count == r_occ_count);
        end
    end

    assign all_sunk = r_all_sunk;
`else
    assign all_sunk = 1'b0;
`endif

endmodule
